// File: rtl/dlk_buffer_ctrl.sv
// Scheduler for the heap-overflow base-address buffer: arbitrates registrations, checks and clears onto one port.
// Optional statistics counters are built when DLK_STATS_EN is defined.
module dlk_buffer_ctrl #(
  parameter int WFIFO_DEPTH = 4,
  parameter int STARVE_MAX  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reg_valid_i,
  output logic        reg_ready_o,
  input  logic [31:0] reg_addr_i,
  input  logic        dbg_valid_i,
  output logic        dbg_ready_o,
  input  logic [31:0] dbg_addr_i,
  input  logic        chk_valid_i,
  output logic        chk_ready_o,
  input  logic [31:0] chk_base_i,
  input  logic [31:0] chk_addr_i,
  output logic        chk_done_o,
  output logic        chk_overflow_o,
  input  logic        clr_i,
  output logic        buf_rst_us_o,
  output logic        buf_en_write_o,
  output logic [31:0] buf_base_addr_o,
  output logic [31:0] buf_read_addr_o,
  input  logic        buf_read_overflow_i,
  output logic        busy_o,
  output logic [15:0] wr_cnt_o,
  output logic [15:0] ovf_cnt_o
);

  localparam int AW = $clog2(WFIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [2:0] {IDLE, WRITE, CHECK, RESP, CLEAR} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fifo_mem [WFIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          fifo_empty, fifo_full;
  logic          alive_q, clr_pend_q, last_dbg_q;
  logic [SW-1:0] starve_q;
  logic          grant_reg, grant_dbg, push, pop;
  logic [31:0]   push_addr;
  logic          en_write_d, rst_us_d, done_d, ovf_d;
  logic [31:0]   base_d, read_d;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // alive_q keeps every ready low until the first clock after reset release
  assign reg_ready_o = alive_q && !fifo_full;
  assign dbg_ready_o = alive_q && !fifo_full;
  assign grant_reg   = reg_valid_i && reg_ready_o && (!dbg_valid_i || last_dbg_q);
  assign grant_dbg   = dbg_valid_i && dbg_ready_o && !grant_reg;
  assign push_addr   = grant_reg ? reg_addr_i : dbg_addr_i;
  // zero matches the buffer's reset contents, and a clear swallows same-cycle registrations
  assign push        = (grant_reg || grant_dbg) && (push_addr != 32'd0) && (state_q != CLEAR);
  assign pop         = (state_q == IDLE) && (state_d == WRITE);
  assign chk_ready_o = (state_q == IDLE) && (state_d == CHECK);
  assign busy_o      = (state_q != IDLE) || !fifo_empty || clr_pend_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (alive_q) begin
          if (clr_pend_q)                                state_d = CLEAR;
          else if ((starve_q == STARVE_LIM) && !fifo_empty) state_d = WRITE;
          else if (chk_valid_i)                          state_d = CHECK;
          else if (!fifo_empty)                          state_d = WRITE;
        end
      end
      WRITE:   state_d = IDLE;
      CHECK:   state_d = RESP;
      RESP:    state_d = IDLE;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // next values for the registered buffer-side outputs; addresses hold outside WRITE/CHECK
  always_comb begin
    en_write_d = (state_d == WRITE);
    rst_us_d   = (state_d == CLEAR);
    done_d     = (state_d == RESP);
    ovf_d      = (state_q == CHECK) && buf_read_overflow_i;
    base_d     = buf_base_addr_o;
    read_d     = buf_read_addr_o;
    if (pop) begin
      base_d = fifo_mem[rd_ptr_q[AW-1:0]];
    end else if (chk_ready_o) begin
      base_d = chk_base_i;
      read_d = chk_addr_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_en_write_o  <= 1'b0;
      buf_rst_us_o    <= 1'b0;
      chk_done_o      <= 1'b0;
      chk_overflow_o  <= 1'b0;
      buf_base_addr_o <= 32'd0;
      buf_read_addr_o <= 32'd0;
    end else begin
      buf_en_write_o  <= en_write_d;
      buf_rst_us_o    <= rst_us_d;
      chk_done_o      <= done_d;
      chk_overflow_o  <= ovf_d;
      buf_base_addr_o <= base_d;
      buf_read_addr_o <= read_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= push_addr;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      alive_q    <= 1'b0;
      last_dbg_q <= 1'b1;
      clr_pend_q <= 1'b0;
      starve_q   <= '0;
    end else begin
      alive_q <= 1'b1;
      if (state_q == CLEAR) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (grant_reg || grant_dbg) begin
        last_dbg_q <= grant_dbg;
      end
      if (clr_i) begin
        clr_pend_q <= 1'b1;
      end else if (state_d == CLEAR) begin
        clr_pend_q <= 1'b0;
      end
      if (fifo_empty || pop) begin
        starve_q <= '0;
      end else if (chk_ready_o && (starve_q != STARVE_LIM)) begin
        starve_q <= starve_q + SW'(1);
      end
    end
  end

`ifdef DLK_STATS_EN
  logic [15:0] wr_cnt_q, ovf_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_cnt_q  <= 16'd0;
      ovf_cnt_q <= 16'd0;
    end else if (state_q == CLEAR) begin
      wr_cnt_q  <= 16'd0;
      ovf_cnt_q <= 16'd0;
    end else begin
      if (pop && (wr_cnt_q != 16'hFFFF)) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
      if ((state_q == RESP) && chk_overflow_o && (ovf_cnt_q != 16'hFFFF)) begin
        ovf_cnt_q <= ovf_cnt_q + 16'd1;
      end
    end
  end

  assign wr_cnt_o  = wr_cnt_q;
  assign ovf_cnt_o = ovf_cnt_q;
`else
  assign wr_cnt_o  = 16'd0;
  assign ovf_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_dlk_buffer_ctrl.sv
// Directed bench for dlk_buffer_ctrl with a small behavioural model of the base-address buffer.
// Statistics expectations follow DLK_STATS_EN.
module tb_dlk_buffer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_valid, dbg_valid, chk_valid, clr;
  logic [31:0] reg_addr, dbg_addr, chk_base, chk_addr;
  logic        reg_ready, dbg_ready, chk_ready, chk_done, chk_ovf;
  logic        buf_rst_us, buf_en_write, buf_ovf, busy;
  logic [31:0] buf_base, buf_read;
  logic [15:0] wr_cnt, ovf_cnt;

  int          checks = 0;
  int          errors = 0;
  int          write_count = 0;
  int          done_count = 0;
  logic [31:0] write_log [$];
  logic [31:0] buf_mem [16];
  int          buf_cnt;
  int          w0, d0;

`ifdef DLK_STATS_EN
  localparam logic [15:0] EXP_WR  = 16'd3;
  localparam logic [15:0] EXP_OVF = 16'd2;
`else
  localparam logic [15:0] EXP_WR  = 16'd0;
  localparam logic [15:0] EXP_OVF = 16'd0;
`endif

  always #5 clk = ~clk;

  dlk_buffer_ctrl #(.WFIFO_DEPTH(4), .STARVE_MAX(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .reg_valid_i(reg_valid), .reg_ready_o(reg_ready), .reg_addr_i(reg_addr),
    .dbg_valid_i(dbg_valid), .dbg_ready_o(dbg_ready), .dbg_addr_i(dbg_addr),
    .chk_valid_i(chk_valid), .chk_ready_o(chk_ready),
    .chk_base_i(chk_base), .chk_addr_i(chk_addr),
    .chk_done_o(chk_done), .chk_overflow_o(chk_ovf),
    .clr_i(clr),
    .buf_rst_us_o(buf_rst_us), .buf_en_write_o(buf_en_write),
    .buf_base_addr_o(buf_base), .buf_read_addr_o(buf_read),
    .buf_read_overflow_i(buf_ovf),
    .busy_o(busy), .wr_cnt_o(wr_cnt), .ovf_cnt_o(ovf_cnt)
  );

  // buffer model: overflow when a registered base lies in (base, read]
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_cnt <= 0;
    end else if (buf_rst_us) begin
      buf_cnt <= 0;
    end else if (buf_en_write && buf_cnt < 16) begin
      buf_mem[buf_cnt] <= buf_base;
      buf_cnt <= buf_cnt + 1;
    end
  end

  always_comb begin
    buf_ovf = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i < buf_cnt && buf_mem[i] > buf_base && buf_mem[i] <= buf_read) buf_ovf = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (buf_en_write) begin
        write_count++;
        write_log.push_back(buf_base);
      end
      if (chk_done) done_count++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] ra, input logic dv, input logic [31:0] da,
                               input logic cv, input logic [31:0] cb, input logic [31:0] ca, input logic cl);
    reg_valid = rv; reg_addr = ra;
    dbg_valid = dv; dbg_addr = da;
    chk_valid = cv; chk_base = cb; chk_addr = ca;
    clr = cl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic regPush(input logic [31:0] addr);
    int n = 0;
    while (!reg_ready && n < 20) begin
      step();
      n++;
    end
    checkOutput("reg_ready_wait", reg_ready, 1);
    applyStimulus(1, addr, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (!busy) break;
      step();
    end
    checkOutput(tag, busy, 0);
  endtask

  task automatic doCheck(input string tag, input logic [31:0] base, input logic [31:0] addr, input logic exp_ovf);
    int n = 0;
    applyStimulus(0, 0, 0, 0, 1, base, addr, 0);
    #1;
    while (!chk_ready && n < 20) begin
      step();
      #1;
      n++;
    end
    checkOutput({tag, "_accept"}, chk_ready, 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput({tag, "_early_done"}, chk_done, 0);
    checkOutput({tag, "_base"}, buf_base, base);
    checkOutput({tag, "_read"}, buf_read, addr);
    step();
    checkOutput({tag, "_done"}, chk_done, 1);
    checkOutput({tag, "_verdict"}, chk_ovf, exp_ovf);
    step();
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("rst_ready", reg_ready, 0);
    checkOutput("rst_en_write", buf_en_write, 0);
    checkOutput("rst_busy", busy, 0);
    step();
    rst = 1'b0;
    #1;
    checkOutput("release_ready_low", reg_ready, 0);
    step();
    checkOutput("release_ready_high", reg_ready, 1);
    checkOutput("release_dbg_ready", dbg_ready, 1);

    // basic registration and two checks
    w0 = write_count;
    regPush(32'h1000);
    regPush(32'h2000);
    waitIdle("basic_idle");
    checkOutput("basic_writes", write_count - w0, 2);
    checkOutput("basic_first", write_log[w0], 32'h1000);
    checkOutput("basic_second", write_log[w0 + 1], 32'h2000);
    doCheck("chk_over", 32'h1000, 32'h2004, 1);
    doCheck("chk_in", 32'h1000, 32'h1FF0, 0);

    // arbitration with both requesters plus starvation under continuous checks
    doReset();
    w0 = write_count;
    d0 = done_count;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(c <= 5, 32'hA000 + c, c <= 5, 32'hB000 + c, c <= 17, 32'h5000, 32'h5000, 0);
      #1;
      if (c == 3) checkOutput("arb_ready_c3", reg_ready, 1);
      if (c == 4) checkOutput("arb_reg_full", reg_ready, 0);
      if (c == 4) checkOutput("arb_dbg_full", dbg_ready, 0);
      if (c == 15) checkOutput("starve_idle", buf_en_write, 0);
      if (c == 16) checkOutput("starve_write", buf_en_write, 1);
      if (c == 16) checkOutput("starve_base", buf_base, 32'hA000);
      if (c == 16) checkOutput("starve_checks", done_count - d0, 5);
      if (c == 19) checkOutput("resume_done", chk_done, 1);
      step();
    end
    checkOutput("arb_writes", write_count - w0, 4);
    checkOutput("arb_order0", write_log[w0], 32'hA000);
    checkOutput("arb_order1", write_log[w0 + 1], 32'hB001);
    checkOutput("arb_order2", write_log[w0 + 2], 32'hA002);
    checkOutput("arb_order3", write_log[w0 + 3], 32'hB003);
    checkOutput("arb_dones", done_count - d0, 6);
    checkOutput("arb_idle", busy, 0);

    // clear during a check with three registrations pending
    doReset();
    w0 = write_count;
    for (int c = 0; c < 14; c++) begin
      applyStimulus((c <= 2) || (c == 7), (c == 7) ? 32'h7000 : 32'h3000 + 32'h1000 * c,
                    0, 0, c <= 3, 32'h3000, 32'h3100, c == 4);
      #1;
      if (c == 4) checkOutput("clr_in_check", chk_done, 0);
      if (c == 5) checkOutput("clr_verdict_done", chk_done, 1);
      if (c == 5) checkOutput("clr_verdict", chk_ovf, 0);
      if (c == 6) checkOutput("clr_not_yet", buf_rst_us, 0);
      if (c == 7) checkOutput("clr_pulse", buf_rst_us, 1);
      if (c == 8) checkOutput("clr_after", buf_rst_us, 0);
      if (c == 8) checkOutput("clr_empty", busy, 0);
      step();
    end
    checkOutput("clr_no_writes", write_count - w0, 0);

    // reset asserted during RESP, then a zero-address registration
    doReset();
    applyStimulus(0, 0, 0, 0, 1, 32'h10, 32'h20, 0);
    #1;
    checkOutput("rstmid_accept", chk_ready, 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    checkOutput("rstmid_resp", chk_done, 1);
    rst = 1'b1;
    #1;
    checkOutput("rstmid_done", chk_done, 0);
    checkOutput("rstmid_base", buf_base, 0);
    checkOutput("rstmid_read", buf_read, 0);
    checkOutput("rstmid_ready", reg_ready, 0);
    checkOutput("rstmid_busy", busy, 0);
    step();
    rst = 1'b0;
    d0 = done_count;
    step();
    w0 = write_count;
    regPush(32'h0);
    repeat (6) step();
    checkOutput("zero_no_write", write_count - w0, 0);
    checkOutput("zero_idle", busy, 0);
    checkOutput("rstmid_no_done", done_count - d0, 0);

    // statistics
    doReset();
    regPush(32'h1000);
    regPush(32'h2000);
    regPush(32'h3000);
    waitIdle("stats_idle");
    doCheck("stats_chk1", 32'h1000, 32'h2004, 1);
    doCheck("stats_chk2", 32'h2000, 32'h3000, 1);
    checkOutput("stats_wr", wr_cnt, EXP_WR);
    checkOutput("stats_ovf", ovf_cnt, EXP_OVF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    waitIdle("stats_clr_idle");
    checkOutput("stats_wr_clr", wr_cnt, 0);
    checkOutput("stats_ovf_clr", ovf_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
